demorgan_sweep_ctrl: RTL and testbench
======================================

# demorgan_sweep_ctrl

Sequencer that exercises a two-input De Morgan gate in hardware. On `start` it walks the gate inputs through all four vectors, holds each vector for a programmable settle time, and samples the gate output. It compares each sample against the expected De Morgan value, then reports a mismatch count and a pass flag. It sits beside the gate as its input driver and output checker, replacing open-loop stimulus with a self-checking sweep.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles each vector is driven before sampling; legal range 1..15.
- `MODE`, default 1: expected function. 0 = `~(a|b)` (equal to `~a & ~b`). 1 = `~(a&b)` (equal to `~a | ~b`).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sampled in IDLE only; begins a sweep.
- `gate_a`  out  1  drives gate input a.
- `gate_b`  out  1  drives gate input b.
- `gate_c`  in  1  gate output under check.
- `busy`  out  1  high from the cycle after start is accepted through the FINISH cycle.
- `done`  out  1  one-cycle pulse in FINISH.
- `pass`  out  1  1 when the last completed sweep had zero mismatches; held until the next start.
- `err_count`  out  3  mismatches in the current or last sweep, 0..4.
- `vec_idx`  out  2  current vector; `gate_a = vec_idx[1]`, `gate_b = vec_idx[0]`.

## Operation
- States: IDLE, SETTLE, CHECK, FINISH.
- **IDLE:** `gate_a`, `gate_b`, `vec_idx` are 0 and `busy` is 0. When `start` is 1, the block clears `err_count`, `pass`, `vec_idx` and the timer, then goes to SETTLE.
- **SETTLE:** drives the vector. The timer increments each cycle. When timer = `HOLD_CYCLES-1`, the next state is CHECK.
- **CHECK:** compares `gate_c` with `expected(vec_idx, MODE)`.
  - On mismatch, `err_count` increments. It cannot exceed 4, so no saturation logic is needed.
  - If `vec_idx` = 3, the next state is FINISH.
  - Otherwise `vec_idx` increments, the timer clears, and the next state is SETTLE.
- **FINISH:** `done` = 1 and `pass` is loaded with (`err_count` == 0). The next state is IDLE.
- Vector order: 00, 01, 10, 11. `b` toggles fastest.
- The vector stays stable through CHECK. It changes only on the edge leaving CHECK.
- `start` is ignored outside IDLE. A `start` held high through FINISH begins a new sweep in the first IDLE cycle.
- `err_count` and `pass` keep their values in IDLE until the next accepted start.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- `rst_n` low mid-sweep aborts immediately and asynchronously. No `done` pulse is produced, and the sweep does not resume.
- Each vector occupies `HOLD_CYCLES+1` cycles: HOLD in SETTLE plus 1 in CHECK.
- Latency: `done` is high in cycle `4*(HOLD_CYCLES+1)+1` after the edge that accepts `start`. At the default, that is cycle 21.
- `gate_c` is sampled at the end of the CHECK cycle. This gives `HOLD_CYCLES+1` cycles of combinational settle.
- `pass` and the final `err_count` are valid in the same cycle that `done` is high.

## Configuration
- Macro `DEMORGAN_SWEEP_FAIL_IDX_EN`.
- **Defined:** adds two ports.
  - `fail_idx` (out, 2): the `vec_idx` of the first mismatch in the sweep.
  - `fail_vld` (out, 1): set on the first mismatch.
  - Both are cleared on start and on reset. Later mismatches do not overwrite them.
- **Undefined:** neither port exists and the related registers are absent. All other behaviour is identical.

## Structure
- Shared package `demorgan_pkg` holds:
  - the state enum (IDLE, SETTLE, CHECK, FINISH);
  - the `MODE_NOR = 0` and `MODE_NAND = 1` constants;
  - the pure function `demorgan_expect(a, b, mode)`.
- One sub-module is natural: `settle_timer`. It is a 4-bit counter with clear, enable and terminal-count output compared against `HOLD_CYCLES-1`.

## Test plan
- **Correct gate, default MODE 1:** stimulus is `gate_c = ~(a&b)` and a start pulse. Require vectors 00, 01, 10, 11 in order; `done` in cycle 21; `err_count` = 0; `pass` = 1.
- **Stuck-at-0 gate:** stimulus is `gate_c` tied to 0. Require `err_count` = 3 and `pass` = 0. With the macro defined, also require `fail_idx` = 0 and `fail_vld` = 1.
- **MODE 0 with a NAND gate:** stimulus is MODE 0 against a gate computing `~(a&b)`. Require mismatches at vectors 01 and 10, `err_count` = 2, and `pass` = 0.
- **HOLD_CYCLES = 1:** require each vector to last exactly 2 cycles and `done` to arrive in cycle 9.
- **Reset mid-sweep:** assert `rst_n` low during vector 10. Require all outputs to drop to 0 immediately, no `done` pulse, and a fresh start to complete normally.
- **Start while busy:** pulse `start` during SETTLE. Require it to be ignored, exactly one `done` pulse, and `busy` low after FINISH.

Source files
------------

// File: rtl/demorgan_pkg.sv
// Shared types and helpers for the De Morgan sweep controller.
// The expected gate truth function lives here so checker and tests agree.
package demorgan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam logic MODE_NOR  = 1'b0;
    localparam logic MODE_NAND = 1'b1;

    function automatic logic demorgan_expect(input logic a, input logic b, input logic mode);
        return (mode == MODE_NAND) ? (~a | ~b) : (~a & ~b);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// 4-bit settle counter: clear has priority, counts while enabled and stops
// at the terminal value HOLD_CYCLES-1, which it flags on tc_o.
module settle_timer #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [3:0] TC_VAL = 4'(HOLD_CYCLES - 1);

    logic [3:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 4'd0;
        else if (en_i && !tc_o)
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 4'd0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/demorgan_sweep_ctrl.sv
// Self-checking driver for a two-input De Morgan gate: walks 00,01,10,11,
// samples the gate after a settle window and reports mismatches.
// Optional first-failure capture ports under DEMORGAN_SWEEP_FAIL_IDX_EN.
module demorgan_sweep_ctrl
    import demorgan_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned MODE        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_c,
`ifdef DEMORGAN_SWEEP_FAIL_IDX_EN
    output logic [1:0] fail_idx,
    output logic       fail_vld,
`endif
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] vec_idx
);

    localparam logic MODE_BIT = (MODE != 0) ? MODE_NAND : MODE_NOR;

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [2:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       tmr_clr, tmr_en, tmr_tc;
    logic       mismatch;

`ifdef DEMORGAN_SWEEP_FAIL_IDX_EN
    logic [1:0] fidx_q, fidx_d;
    logic       fvld_q, fvld_d;
`endif

    settle_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    assign mismatch = (gate_c != demorgan_expect(vec_q[1], vec_q[0], MODE_BIT));

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        pass_d  = pass_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
`ifdef DEMORGAN_SWEEP_FAIL_IDX_EN
        fidx_d  = fidx_q;
        fvld_d  = fvld_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = 3'd0;
                    pass_d  = 1'b0;
                    vec_d   = 2'd0;
                    tmr_clr = 1'b1;
`ifdef DEMORGAN_SWEEP_FAIL_IDX_EN
                    fidx_d  = 2'd0;
                    fvld_d  = 1'b0;
`endif
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_tc) state_d = CHECK;
            end
            CHECK: begin
                // At most four checks per sweep, so the 3-bit count never wraps.
                if (mismatch) begin
                    err_d = err_q + 3'd1;
`ifdef DEMORGAN_SWEEP_FAIL_IDX_EN
                    if (!fvld_q) begin
                        fidx_d = vec_q;
                        fvld_d = 1'b1;
                    end
`endif
                end
                if (vec_q == 2'd3) begin
                    state_d = FINISH;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    tmr_clr = 1'b1;
                    state_d = SETTLE;
                end
            end
            FINISH: begin
                pass_d  = (err_q == 3'd0);
                vec_d   = 2'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            err_q   <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

`ifdef DEMORGAN_SWEEP_FAIL_IDX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fidx_q <= 2'd0;
            fvld_q <= 1'b0;
        end else begin
            fidx_q <= fidx_d;
            fvld_q <= fvld_d;
        end
    end

    assign fail_idx = fidx_q;
    assign fail_vld = fvld_q;
`endif

    // pass must already reflect the verdict in the FINISH cycle itself.
    assign pass      = (state_q == FINISH) ? (err_q == 3'd0) : pass_q;
    assign done      = (state_q == FINISH);
    assign busy      = (state_q != IDLE);
    assign err_count = err_q;
    assign vec_idx   = vec_q;
    assign gate_a    = vec_q[1];
    assign gate_b    = vec_q[0];

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Bench: instance 0 is NAND-checking with default hold, instance 1 is
// NOR-checking with a one-cycle hold; gates are modelled as truth tables.
module tb_demorgan_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       st   [2];
    logic       ga   [2];
    logic       gb   [2];
    logic       gc   [2];
    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic [2:0] err  [2];
    logic [1:0] vec  [2];
    logic [3:0] tbl  [2];
`ifdef DEMORGAN_SWEEP_FAIL_IDX_EN
    logic [1:0] fidx [2];
    logic       fvld [2];
`endif

    int checks = 0;
    int errors = 0;
    int exp_err  [2];
    int exp_pass [2];

    // Gate under check: output looked up from a truth table indexed by {a,b}.
    assign gc[0] = tbl[0][{ga[0], gb[0]}];
    assign gc[1] = tbl[1][{ga[1], gb[1]}];

    demorgan_sweep_ctrl #(.HOLD_CYCLES(4), .MODE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]),
        .gate_a(ga[0]), .gate_b(gb[0]), .gate_c(gc[0]),
`ifdef DEMORGAN_SWEEP_FAIL_IDX_EN
        .fail_idx(fidx[0]), .fail_vld(fvld[0]),
`endif
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err[0]), .vec_idx(vec[0])
    );

    demorgan_sweep_ctrl #(.HOLD_CYCLES(1), .MODE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]),
        .gate_a(ga[1]), .gate_b(gb[1]), .gate_c(gc[1]),
`ifdef DEMORGAN_SWEEP_FAIL_IDX_EN
        .fail_idx(fidx[1]), .fail_vld(fvld[1]),
`endif
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err[1]), .vec_idx(vec[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int s, input string tag);
        chk({tag, "_vec"},  8'(vec[s]), 8'd0);
        chk({tag, "_gab"},  8'({ga[s], gb[s]}), 8'd0);
        chk({tag, "_busy"}, 8'(busy[s]), 8'd0);
        chk({tag, "_done"}, 8'(done[s]), 8'd0);
        chk({tag, "_err"},  8'(err[s]), 8'(exp_err[s]));
        chk({tag, "_pass"}, 8'(pass[s]), 8'(exp_pass[s]));
    endtask

    // Runs one full sweep on instance s against truth table t; an optional
    // extra start pulse is driven in cycle glitch_at of the sweep.
    task automatic do_sweep(input int s, input logic [3:0] t, input int glitch_at);
        int h, n, cur, eerr, efirst;
        int pre [5];
        logic [3:0] etbl;
        h = (s == 0) ? 4 : 1;
        for (int v = 0; v < 4; v++)
            etbl[v] = (s == 0) ? (v != 3) : (v == 0);   // NAND low only at 11; NOR high only at 00
        eerr = 0; efirst = -1;
        for (int v = 0; v < 4; v++) begin
            pre[v] = eerr;
            if (t[v] != etbl[v]) begin
                eerr++;
                if (efirst < 0) efirst = v;
            end
        end
        pre[4] = eerr;
        tbl[s] = t;
        st[s] = 1'b1;
        @(negedge clk);
        st[s] = 1'b0;
        n = 4 * (h + 1);
        for (int k = 1; k <= n; k++) begin
            cur = (k - 1) / (h + 1);
            chk("sweep_vec",  8'(vec[s]), 8'(cur));
            chk("sweep_gab",  8'({ga[s], gb[s]}), 8'(cur));
            chk("sweep_busy", 8'(busy[s]), 8'd1);
            chk("sweep_done", 8'(done[s]), 8'd0);
            chk("sweep_pass", 8'(pass[s]), 8'd0);
            chk("sweep_err",  8'(err[s]), 8'(pre[cur]));
            st[s] = (k == glitch_at);
            @(negedge clk);
        end
        st[s] = 1'b0;
        chk("fin_done", 8'(done[s]), 8'd1);
        chk("fin_busy", 8'(busy[s]), 8'd1);
        chk("fin_err",  8'(err[s]), 8'(eerr));
        chk("fin_pass", 8'(pass[s]), 8'(eerr == 0));
`ifdef DEMORGAN_SWEEP_FAIL_IDX_EN
        chk("fin_fvld", 8'(fvld[s]), 8'(eerr != 0));
        if (eerr != 0) chk("fin_fidx", 8'(fidx[s]), 8'(efirst));
`endif
        exp_err[s]  = eerr;
        exp_pass[s] = (eerr == 0);
        @(negedge clk);
        chk_idle(s, "after");
        @(negedge clk);
        chk_idle(s, "after2");
    endtask

    initial begin
        rst_n = 1'b0;
        st[0] = 1'b0; st[1] = 1'b0;
        tbl[0] = 4'b0111; tbl[1] = 4'b0001;
        exp_err[0] = 0; exp_err[1] = 0; exp_pass[0] = 0; exp_pass[1] = 0;
        #3;
        chk_idle(0, "rst0");
        chk_idle(1, "rst1");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle(0, "idle0");

        do_sweep(0, 4'b0111, 0);   // correct NAND, done in cycle 21
        do_sweep(0, 4'b0000, 0);   // stuck-at-0: 3 errors, first at 00
        do_sweep(1, 4'b0111, 0);   // NOR check vs NAND gate: misses at 01,10
        do_sweep(1, 4'b0001, 0);   // correct NOR, one-cycle hold
        do_sweep(0, 4'b0111, 3);   // start pulse while busy is ignored

        // Reset during vector 10.
        tbl[0] = 4'b0111;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_vec", 8'(vec[0]), 8'd2);
        #2 rst_n = 1'b0;
        exp_err[0] = 0; exp_pass[0] = 0; exp_err[1] = 0; exp_pass[1] = 0;
        #1;
        chk_idle(0, "async_rst0");
        chk_idle(1, "async_rst1");
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", 8'(done[0]), 8'd0);
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("no_resume_busy", 8'(busy[0]), 8'd0);
            chk("no_resume_done", 8'(done[0]), 8'd0);
        end
        do_sweep(0, 4'b0111, 0);

        for (int r = 0; r < 8; r++)
            do_sweep(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 12)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
